// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - shared sample-path parameters and player state type
package ma_pkg;

    localparam int N      = 16;
    localparam int DEPTH  = 95;
    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - sample table, one synchronous write port, one combinational read port
module sample_ram #(
    parameter int N      = ma_pkg::N,
    parameter int DEPTH  = ma_pkg::DEPTH,
    parameter int ADDR_W = ma_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [N-1:0]      rd_data
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [N-1:0] mem_q [DEPTH];

    // Out-of-range writes are dropped rather than aliased onto a low address.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sample_player.sv
// rtl/sample_player.sv - streams the sample table to the MA filter, one-shot or looping
module sample_player #(
    parameter int N      = ma_pkg::N,
    parameter int DEPTH  = ma_pkg::DEPTH,
    parameter int ADDR_W = ma_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    import ma_pkg::state_t, ma_pkg::IDLE, ma_pkg::PLAY, ma_pkg::DRAIN;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, rd_addr;
    logic [N-1:0]      data_q, data_d, rd_data;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              xfer;

    assign xfer     = valid_q & out_ready;
    assign addr_inc = (addr_q == LAST) ? '0 : addr_q + 1'b1;
    // addr_q tracks the sample in out_data, so once valid the read port looks one ahead.
    assign rd_addr  = valid_q ? addr_inc : addr_q;

    sample_ram #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = PLAY;
                    addr_d  = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    if (!valid_q || xfer) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (!valid_q) begin
                    data_d  = rd_data;
                    valid_d = 1'b1;
                end else if (xfer) begin
                    if ((addr_q == LAST) && !loop_mode) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_inc;
                        data_d = rd_data;
                        wrap_d = (addr_q == LAST);
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sample_player.sv
// tb/tb_sample_player.sv - randomized self-checking bench for sample_player
module tb_sample_player;

    localparam int N     = 16;
    localparam int DEPTH = 95;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic          start = 1'b0, stop = 1'b0, loop_mode = 1'b0, out_ready = 1'b0;
    logic          out_valid, busy, wrap, done;
    logic [N-1:0]  out_data;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] tbl [DEPTH];

    always #5 clk = ~clk;

    sample_player #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .loop_mode (loop_mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, busy, wrap, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h b=%b w=%b dn=%b, want all 0",
                     out_valid, out_data, busy, wrap, done);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_addr = AW'(i);
            wr_data = N'(i + 100);
            tbl[i] = N'(i + 100);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_oneshot();
        int idx = 0, ndone = 0, cyc = 0;
        loop_mode = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_edge1: got v=%b b=%b, want v=0 b=1", out_valid, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_latency: got v=%b, want 1", out_valid);
        end
        while (busy && cyc < 300) begin
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== tbl[idx]) begin
                    errors++;
                    $display("FAIL oneshot_data[%0d]: got %h, want %h", idx, out_data, tbl[idx]);
                end
                idx++;
            end
            checks++;
            if (wrap !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_wrap: got %b, want 0", wrap);
            end
            tick();
            cyc++;
            if (done) ndone++;
        end
        checks++;
        if (idx != DEPTH || ndone != 1 || out_valid !== 1'b0 || cyc >= 300) begin
            errors++;
            $display("FAIL oneshot_end: got count=%0d done=%0d v=%b cyc=%0d, want count=%0d done=1 v=0",
                     idx, ndone, out_valid, cyc, DEPTH);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done_pulse: got %b, want 0", done);
        end
    endtask

    task automatic test_loop();
        int idx = 0, transfers = 0, wraps = 0;
        logic exp_wrap = 1'b0, pend = 1'b0;
        out_ready = 1'b1;
        loop_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        while (transfers < 3 * DEPTH + 10) begin
            checks++;
            if (wrap !== exp_wrap || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL loop_wrap[%0d]: got w=%b v=%b, want w=%b v=1", transfers, wrap, out_valid, exp_wrap);
            end
            checks++;
            if (out_data !== tbl[idx]) begin
                errors++;
                $display("FAIL loop_data[%0d]: got %h, want %h", idx, out_data, tbl[idx]);
            end
            wr_en = 1'b0;
            if (transfers == 20) begin
                wr_en = 1'b1;
                wr_addr = AW'(21);
                wr_data = 16'h5555;
                pend = 1'b1;
            end
            if (idx == 21 && pend && transfers > 20) begin
                tbl[21] = 16'h5555;
                pend = 1'b0;
            end
            loop_mode = (idx == DEPTH - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_wrap = (idx == DEPTH - 1);
            if (exp_wrap) wraps++;
            idx = (idx + 1) % DEPTH;
            transfers++;
            tick();
        end
        wr_en = 1'b0;
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== tbl[idx] || wraps != 3) begin
            errors++;
            $display("FAIL loop_stop_hold: got v=%b d=%h wraps=%0d, want v=1 d=%h wraps=3",
                     out_valid, out_data, wraps, tbl[idx]);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop_done: got dn=%b v=%b b=%b, want 1 0 0", done, out_valid, busy);
        end
    endtask

    task automatic test_random_ready();
        int idx = 0, ndone = 0, cyc = 0;
        logic held = 1'b0;
        logic [N-1:0] held_data = '0;
        loop_mode = 1'b0;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (busy && cyc < 1000) begin
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    errors++;
                    $display("FAIL rand_hold: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, held_data);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            held = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== tbl[idx]) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h, want %h", idx, out_data, tbl[idx]);
                end
                idx++;
            end
            tick();
            cyc++;
            if (done) ndone++;
        end
        checks++;
        if (idx != DEPTH || ndone != 1 || cyc >= 1000) begin
            errors++;
            $display("FAIL rand_end: got count=%0d done=%0d cyc=%0d, want count=%0d done=1", idx, ndone, cyc, DEPTH);
        end
    endtask

    task automatic test_stop();
        int idx = 0, cyc = 0, extra = 0;
        int k = $urandom_range(10, 60);
        loop_mode = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (idx < k && cyc < 200) begin
            if (out_valid) idx++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== tbl[k] || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stop_hold[%0d]: got v=%b d=%h dn=%b b=%b, want 1 %h 0 1",
                         i, out_valid, out_data, done, busy, tbl[k]);
            end
        end
        stop = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_done: got dn=%b v=%b, want 1 0", done, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_after: got extra=%0d b=%b, want 0 0", extra, busy);
        end
        start = 1'b1;
        stop = 1'b1;
        tick();
        tick();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: got b=%b v=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0, cyc = 0;
        loop_mode = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (idx < 40 && cyc < 200) begin
            if (out_valid) idx++;
            tick();
            cyc++;
        end
        checks++;
        if (out_data !== tbl[40]) begin
            errors++;
            $display("FAIL mid_addr40: got %h, want %h", out_data, tbl[40]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, busy, wrap, done} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: got v=%b d=%h b=%b w=%b dn=%b, want all 0",
                     out_valid, out_data, busy, wrap, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: got %b, want 0", done);
        end
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'hBEEF;
        wr_addr = AW'(95);
        tick();
        wr_addr = AW'(127);
        tick();
        wr_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (busy && cyc < 300) begin
            if (out_valid) begin
                checks++;
                if (out_data !== tbl[idx]) begin
                    errors++;
                    $display("FAIL mid_replay[%0d]: got %h, want %h", idx, out_data, tbl[idx]);
                end
                idx++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (idx != DEPTH) begin
            errors++;
            $display("FAIL mid_replay_count: got %0d, want %0d", idx, DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_random_ready();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
